// File: rtl/core_types_pkg.sv
// Shared core types: word type, RAM handshake state and address-space sizing.
package core_types_pkg;

  localparam int WORD_W                = 32;
  localparam int WORD_ADDR_SPACE_WIDTH = 14;  // 16-bit byte space, word granular
  localparam int RAM_LAT               = 2;   // default BUSY cycles before ACCESS
  localparam int RAM_LANES             = 4;
  localparam int RAM_LANE_W            = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// Byte-lane writable word array: async read, synchronous masked write, no reset.
module ram_array #(
  parameter int WORDS     = 16384,
  parameter int AW        = 14,
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8
) (
  input  logic                              clk_i,
  input  logic                              we_i,
  input  logic [NUM_LANES-1:0]              ben_i,
  input  logic [AW-1:0]                     addr_i,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  wdata_i,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  rdata_o
);

  // Each byte lane is its own storage column so a masked write only touches enabled lanes.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] mem_q [WORDS];

    // Lane write, committed only when this lane's enable is set
    always_ff @(posedge clk_i) begin
      if (we_i && ben_i[l]) mem_q[addr_i] <= wdata_i[l];
    end

    assign rdata_o[l] = mem_q[addr_i];
  end

endmodule

// File: rtl/ram_responder.sv
// RAM responder: counts LAT BUSY cycles per request, then one ACCESS cycle.
module ram_responder
  import core_types_pkg::*;
#(
  parameter int LAT       = RAM_LAT,
  parameter int MEM_WORDS = 2**WORD_ADDR_SPACE_WIDTH
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  input  logic [3:0] ramBEN,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int AW = WORD_ADDR_SPACE_WIDTH;
  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = (LAT < 1) ? '0 : CW'(LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lat_valid_q, lat_valid_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic          lat_wen_q, lat_wen_d;

  logic [AW-1:0] waddr;
  logic          req, err, match;
  logic          wr_en, rd_en;
  word_t         rdata;
  logic          unused_addr_hi;

  assign waddr          = ramaddr[AW+1:2];
  assign unused_addr_hi = ^ramaddr[WORD_W-1:AW+2];

  assign req   = ramREN | ramWEN;
  assign err   = (ramREN & ramWEN) | (req & (ramaddr[1:0] != 2'b00));
  // Same request as the one being counted: any change restarts the latency.
  assign match = lat_valid_q & (lat_addr_q == waddr) & (lat_wen_q == ramWEN);

  // Handshake decode, purely from the live request and the latched one
  always_comb begin
    ramstate = BUSY;
    if (!req)                                    ramstate = FREE;
    else if (err)                                ramstate = ERROR;
    else if ((LAT == 0) || (match && cnt_q == '0)) ramstate = ACCESS;
  end

  // Latency bookkeeping: latch a new request, count it down, retire on ACCESS
  always_comb begin
    cnt_d       = cnt_q;
    lat_valid_d = lat_valid_q;
    lat_addr_d  = lat_addr_q;
    lat_wen_d   = lat_wen_q;
    if (!req || err) begin
      lat_valid_d = 1'b0;
    end else if (LAT != 0) begin
      if (!match) begin
        lat_valid_d = 1'b1;
        lat_addr_d  = waddr;
        lat_wen_d   = ramWEN;
        cnt_d       = CNT_INIT;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        // ACCESS cycle: a request still held afterwards is a fresh access
        lat_valid_d = 1'b0;
      end
    end
  end

  // Latch registers; reset drops any in-flight request
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q       <= '0;
      lat_valid_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wen_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      lat_valid_q <= lat_valid_d;
      lat_addr_q  <= lat_addr_d;
      lat_wen_q   <= lat_wen_d;
    end
  end

  // Reset gates both ports so a LAT=0 access cannot slip through while held in reset.
  assign wr_en   = nRST & (ramstate == ACCESS) & ramWEN;
  assign rd_en   = nRST & (ramstate == ACCESS) & ramREN;
  assign ramload = rd_en ? rdata : '0;

  ram_array #(
    .WORDS    (MEM_WORDS),
    .AW       (AW),
    .NUM_LANES(RAM_LANES),
    .LANE_W   (RAM_LANE_W)
  ) u_array (
    .clk_i  (CLK),
    .we_i   (wr_en),
    .ben_i  (ramBEN),
    .addr_i (waddr),
    .wdata_i(ramstore),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Bench: table of per-cycle vectors with a scoreboard queue, plus reset sequences.
module tb_ram_responder;
  import core_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;

  logic       ren2 = 1'b0, wen2 = 1'b0;
  word_t      addr2 = '0, st2 = '0, ld2;
  logic [3:0] ben2 = '0;
  ramstate_t  rs2;

  logic       ren0 = 1'b0, wen0 = 1'b0;
  word_t      addr0 = '0, st0 = '0, ld0;
  logic [3:0] ben0 = '0;
  ramstate_t  rs0;

  ram_responder #(.LAT(2)) dut (
    .CLK(CLK), .nRST(nRST), .ramREN(ren2), .ramWEN(wen2), .ramaddr(addr2),
    .ramstore(st2), .ramBEN(ben2), .ramload(ld2), .ramstate(rs2)
  );

  ram_responder #(.LAT(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren0), .ramWEN(wen0), .ramaddr(addr0),
    .ramstore(st0), .ramBEN(ben0), .ramload(ld0), .ramstate(rs0)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         sel;   // 0: LAT=2 instance, 1: LAT=0 instance
    bit         ren, wen;
    word_t      addr, store;
    logic [3:0] ben;
    ramstate_t  st;
    word_t      ld;
  } vec_t;

  typedef struct {
    bit        sel;
    ramstate_t st;
    word_t     ld;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(bit sel, bit ren, bit wen, word_t a, word_t s,
                              logic [3:0] b, ramstate_t st, word_t ld);
    vec_t v;
    v.sel = sel; v.ren = ren; v.wen = wen; v.addr = a; v.store = s;
    v.ben = b; v.st = st; v.ld = ld;
    return v;
  endfunction

  function automatic void wr(bit sel, word_t a, word_t s, logic [3:0] b, ramstate_t st);
    vecs.push_back(mk(sel, 1'b0, 1'b1, a, s, b, st, '0));
  endfunction

  function automatic void rd(bit sel, word_t a, ramstate_t st, word_t ld);
    vecs.push_back(mk(sel, 1'b1, 1'b0, a, '0, 4'h0, st, ld));
  endfunction

  function automatic void idl(bit sel);
    vecs.push_back(mk(sel, 1'b0, 1'b0, '0, '0, 4'h0, FREE, '0));
  endfunction

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d got %h want %h", name, tag, act, exp);
    end
  endtask

  // Pop the oldest expectation at the falling edge and compare against the DUT.
  task automatic sample(input int tag);
    exp_t e;
    @(negedge CLK);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty #%0d", tag);
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      check("state0", tag, 32'(rs0), 32'(e.st));
      check("load0",  tag, ld0, e.ld);
    end else begin
      check("state2", tag, 32'(rs2), 32'(e.st));
      check("load2",  tag, ld2, e.ld);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.sel = v.sel; e.st = v.st; e.ld = v.ld;
    sb.push_back(e);
  endtask

  task automatic apply(input vec_t v, input int tag);
    @(posedge CLK);
    #1;
    if (v.sel) begin
      ren0 = v.ren; wen0 = v.wen; addr0 = v.addr; st0 = v.store; ben0 = v.ben;
    end else begin
      ren2 = v.ren; wen2 = v.wen; addr2 = v.addr; st2 = v.store; ben2 = v.ben;
    end
    push_exp(v);
    sample(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;

    // Reset state, with and without a request pending
    #2;
    check("rst_state2", 0, 32'(rs2), 32'(FREE));
    check("rst_load2",  0, ld2, 32'h0);
    check("rst_state0", 0, 32'(rs0), 32'(FREE));
    ren2 = 1'b1; addr2 = 32'h40;
    #1;
    check("rst_req_state2", 0, 32'(rs2), 32'(BUSY));
    check("rst_req_load2",  0, ld2, 32'h0);
    ren2 = 1'b0; addr2 = '0;
    @(negedge CLK);
    nRST = 1'b1;

    // Full-word write then read back
    wr(0, 32'h40, 32'hDEADBEEF, 4'hF, BUSY); wr(0, 32'h40, 32'hDEADBEEF, 4'hF, BUSY);
    wr(0, 32'h40, 32'hDEADBEEF, 4'hF, ACCESS); idl(0);
    rd(0, 32'h40, BUSY, 0); rd(0, 32'h40, BUSY, 0); rd(0, 32'h40, ACCESS, 32'hDEADBEEF); idl(0);
    // Byte-lane merge
    wr(0, 32'h40, 32'h11223344, 4'b0101, BUSY); wr(0, 32'h40, 32'h11223344, 4'b0101, BUSY);
    wr(0, 32'h40, 32'h11223344, 4'b0101, ACCESS); idl(0);
    rd(0, 32'h40, BUSY, 0); rd(0, 32'h40, BUSY, 0); rd(0, 32'h40, ACCESS, 32'hDE22BE44); idl(0);
    // Second location for the address-change case
    wr(0, 32'h80, 32'hCAFEF00D, 4'hF, BUSY); wr(0, 32'h80, 32'hCAFEF00D, 4'hF, BUSY);
    wr(0, 32'h80, 32'hCAFEF00D, 4'hF, ACCESS); idl(0);
    // Address changes in the second BUSY cycle: count restarts
    rd(0, 32'h40, BUSY, 0); rd(0, 32'h80, BUSY, 0); rd(0, 32'h80, BUSY, 0);
    rd(0, 32'h80, ACCESS, 32'hCAFEF00D); idl(0);
    // Write dropped after one cycle leaves memory untouched
    wr(0, 32'h40, 32'hFFFFFFFF, 4'hF, BUSY); idl(0); idl(0);
    rd(0, 32'h40, BUSY, 0); rd(0, 32'h40, BUSY, 0); rd(0, 32'h40, ACCESS, 32'hDE22BE44); idl(0);
    // Errors: both enables, misaligned write held, misaligned read
    vecs.push_back(mk(0, 1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, ERROR, '0));
    idl(0);
    wr(0, 32'h42, 32'hFFFFFFFF, 4'hF, ERROR); wr(0, 32'h42, 32'hFFFFFFFF, 4'hF, ERROR);
    rd(0, 32'h42, ERROR, 0); idl(0);
    rd(0, 32'h40, BUSY, 0); rd(0, 32'h40, BUSY, 0); rd(0, 32'h40, ACCESS, 32'hDE22BE44); idl(0);
    // Held write repeats with full latency each time
    for (int i = 0; i < 2; i++) begin
      wr(0, 32'h44, 32'h12345678, 4'hF, BUSY); wr(0, 32'h44, 32'h12345678, 4'hF, BUSY);
      wr(0, 32'h44, 32'h12345678, 4'hF, ACCESS);
    end
    idl(0);
    rd(0, 32'h44, BUSY, 0); rd(0, 32'h44, BUSY, 0); rd(0, 32'h44, ACCESS, 32'h12345678); idl(0);
    // Read switches to write on the same address: restart, then dropped
    rd(0, 32'h44, BUSY, 0); wr(0, 32'h44, 32'h0, 4'hF, BUSY); idl(0);
    rd(0, 32'h44, BUSY, 0); rd(0, 32'h44, BUSY, 0); rd(0, 32'h44, ACCESS, 32'h12345678); idl(0);
    // Seed for the reset tests
    wr(0, 32'h100, 32'h0BADF00D, 4'hF, BUSY); wr(0, 32'h100, 32'h0BADF00D, 4'hF, BUSY);
    wr(0, 32'h100, 32'h0BADF00D, 4'hF, ACCESS); idl(0);
    // LAT=0: back-to-back writes then back-to-back reads
    wr(1, 32'h0, 32'h11111111, 4'hF, ACCESS); wr(1, 32'h4, 32'h22222222, 4'hF, ACCESS);
    wr(1, 32'h8, 32'h33333333, 4'hF, ACCESS); wr(1, 32'hC, 32'h44444444, 4'hF, ACCESS);
    rd(1, 32'h0, ACCESS, 32'h11111111); rd(1, 32'h4, ACCESS, 32'h22222222);
    rd(1, 32'h8, ACCESS, 32'h33333333); rd(1, 32'hC, ACCESS, 32'h44444444);
    rd(1, 32'h2, ERROR, 0); idl(1);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-BUSY of a write, request dropped during reset: no write
    v = mk(0, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, 4'hF, BUSY, '0);
    apply(v, 1000);
    apply(v, 1001);
    #1 nRST = 1'b0;
    apply(v, 1002);  // would have been ACCESS without the reset
    apply(v, 1003);
    apply(mk(0, 1'b0, 1'b0, '0, '0, 4'h0, FREE, '0), 1004);
    #1 nRST = 1'b1;
    apply(mk(0, 1'b1, 1'b0, 32'h100, '0, 4'h0, BUSY, '0), 1005);
    apply(mk(0, 1'b1, 1'b0, 32'h100, '0, 4'h0, BUSY, '0), 1006);
    apply(mk(0, 1'b1, 1'b0, 32'h100, '0, 4'h0, ACCESS, 32'h0BADF00D), 1007);
    apply(mk(0, 1'b0, 1'b0, '0, '0, 4'h0, FREE, '0), 1008);

    // Reset mid-BUSY, released with the request held: full latency again
    apply(v, 1100);
    #1 nRST = 1'b0;
    @(posedge CLK);
    #2 nRST = 1'b1;
    push_exp(v);
    sample(1101);
    apply(v, 1102);
    v.st = ACCESS;
    apply(v, 1103);
    apply(mk(0, 1'b0, 1'b0, '0, '0, 4'h0, FREE, '0), 1104);
    apply(mk(0, 1'b1, 1'b0, 32'h100, '0, 4'h0, BUSY, '0), 1105);
    apply(mk(0, 1'b1, 1'b0, 32'h100, '0, 4'h0, BUSY, '0), 1106);
    apply(mk(0, 1'b1, 1'b0, 32'h100, '0, 4'h0, ACCESS, 32'hA5A5A5A5), 1107);
    apply(mk(0, 1'b0, 1'b0, '0, '0, 4'h0, FREE, '0), 1108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
